// File: rtl/seq_player_pkg.sv
// Shared Genius game package: colour encoding, default round width and the
// seq_player state encoding. Also used by the game controller and the
// user-input checker.
package seq_player_pkg;

    localparam int RW_DEFAULT = 5;

    localparam logic [1:0] COL_GREEN  = 2'd0;
    localparam logic [1:0] COL_RED    = 2'd1;
    localparam logic [1:0] COL_YELLOW = 2'd2;
    localparam logic [1:0] COL_BLUE   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHOW  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } sp_state_t;

    // Colour code to one-hot LED pattern: led[colour] lit.
    function automatic logic [3:0] colour_onehot(input logic [1:0] c);
        colour_onehot = 4'b0001 << c;
    endfunction

endpackage

// File: rtl/seq_player_if.sv
// Sequence memory read bus. Handshake: the master drives mem_addr and the
// slave returns the colour on mem_data one clock later (registered read);
// there is no valid/ready, the read always completes in exactly one cycle.
interface seq_player_if import seq_player_pkg::*; #(
    parameter int RW = RW_DEFAULT
) ();
    logic [RW-1:0] mem_addr;
    logic [1:0]    mem_data;

    modport master (output mem_addr, input mem_data);
    modport slave  (input mem_addr, output mem_data);
endinterface

// File: rtl/seq_player_timer.sv
// seq_timer: loadable down-counter. done is high in the last cycle of a
// loaded interval, so loading N gives an interval of exactly N cycles.
module seq_timer #(
    parameter int CW = 8
) (
    input  logic          CLOCK,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] count;

    // Load takes priority; otherwise count down and park at zero.
    always_ff @(posedge CLOCK) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign done = (count == CW'(1));

endmodule

// File: rtl/seq_player.sv
// seq_player: plays the stored colour sequence (index 0..round) on the LEDs
// while the game controller holds enable, then reports end_FPGA.
module seq_player import seq_player_pkg::*; #(
    parameter int RW         = RW_DEFAULT,
    parameter int ON_CYCLES  = 50_000_000,
    parameter int OFF_CYCLES = 12_500_000
) (
    input  logic             CLOCK,
    input  logic             reset,
    input  logic             enable,
    input  logic [RW-1:0]    round,
    input  logic [1:0]       speed,
    seq_player_if.master     mem,
    output logic [3:0]       led,
    output logic             busy,
    output logic             end_FPGA,
    output sp_state_t        state_dbg
);

    localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] ON_LEN0 = CW'(ON_CYCLES);
    localparam logic [CW-1:0] OFF_LEN = CW'(OFF_CYCLES);

    sp_state_t     state, state_next;
    logic [RW-1:0] rnd_q;
    logic [RW-1:0] idx;
    logic [RW-1:0] addr_q;
    logic [1:0]    col_q;
    logic [CW-1:0] on_q;
    logic [CW-1:0] on_calc;
    logic          timer_load;
    logic [CW-1:0] timer_val;
    logic          timer_done;
    logic          start;
    logic          advance;

    // Speed-scaled on-time, clamped so a large shift never yields zero.
    always_comb begin
        on_calc = ON_LEN0 >> speed;
        if (on_calc == '0) begin
            on_calc = CW'(1);
        end
    end

    assign start   = (state == ST_IDLE) && enable;
    assign advance = (state == ST_GAP) && enable && timer_done && (idx != rnd_q);

    // State register plus run context: round/speed latched only at start,
    // so later changes on the inputs have no effect on the current run.
    always_ff @(posedge CLOCK) begin
        if (reset) begin
            state  <= ST_IDLE;
            rnd_q  <= '0;
            idx    <= '0;
            addr_q <= '0;
            col_q  <= '0;
            on_q   <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                rnd_q  <= round;
                on_q   <= on_calc;
                idx    <= '0;
                addr_q <= '0;
            end
            if (state == ST_LOAD) begin
                col_q <= mem.mem_data;
            end
            // idx is compared against rnd_q before incrementing, so the last
            // entry of a full-range round never wraps back to zero.
            if (advance) begin
                idx    <= idx + RW'(1);
                addr_q <= idx + RW'(1);
            end
        end
    end

    // Next state, timer control and LED drive; abort overrides everything.
    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        timer_val  = on_q;
        led        = 4'b0000;
        case (state)
            ST_IDLE: begin
                if (enable) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                timer_load = 1'b1;
                timer_val  = on_q;
                state_next = ST_SHOW;
            end
            ST_SHOW: begin
                led = colour_onehot(col_q);
                if (timer_done) begin
                    timer_load = 1'b1;
                    timer_val  = OFF_LEN;
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (timer_done) begin
                    state_next = (idx == rnd_q) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (!enable && state != ST_IDLE) begin
            state_next = ST_IDLE;
        end
    end

    seq_timer #(.CW(CW)) u_timer (
        .CLOCK    (CLOCK),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    assign mem.mem_addr = addr_q;
    assign busy         = (state != ST_IDLE) && (state != ST_DONE);
    assign end_FPGA     = (state == ST_DONE);
    assign state_dbg    = state;

endmodule
